// File: rtl/button_pkg.sv
// Shared button-conditioning definitions: debounce FSM state encoding and
// the default debounce length for a 100 MHz board clock.
package button_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_IDLE         = 2'd0;
    localparam btn_state_t ST_PRESS_WAIT   = 2'd1;
    localparam btn_state_t ST_HELD         = 2'd2;
    localparam btn_state_t ST_RELEASE_WAIT = 2'd3;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/button_press_pulser_sync_2ff.sv
// Two-flop synchroniser with synchronous reset, reusable for any
// asynchronous board input.
module sync_2ff (
    input  logic CLK_IN,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/button_press_pulser.sv
// Debounces a raw push-button into a clean level plus one-cycle press/release
// pulses. Define BUTTON_PRESS_PULSER_AUTOREPEAT_EN to add hold-to-repeat pulses.
module button_press_pulser
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 32
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        $clog2(DEBOUNCE_CYCLES + 1) > CNT_W) begin : g_bad_params
        $error("button_press_pulser: invalid parameter set");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             btn_s;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_evt;
    logic             rel_evt;
    logic             press_fire;

    sync_2ff u_sync (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .d      (button),
        .q      (btn_s)
    );

    // Any disagreement with the target level restarts the debounce window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        rel_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_s) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_HELD;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = ST_HELD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_IDLE;
                    rel_evt   = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BUTTON_PRESS_PULSER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic             rep_phase;
    logic             rep_phase_nxt;
    logic             rep_evt;

    // Counts only on edges that stay in HELD; frozen through release bounces.
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_phase_nxt = rep_phase;
        rep_evt       = 1'b0;
        if (state == ST_HELD && btn_s) begin
            if (!rep_phase) begin
                if (rep_cnt == RD_LAST) begin
                    rep_evt       = 1'b1;
                    rep_phase_nxt = 1'b1;
                    rep_cnt_nxt   = '0;
                end else begin
                    rep_cnt_nxt = sat_inc(rep_cnt);
                end
            end else if (rep_cnt == RP_LAST) begin
                rep_evt     = 1'b1;
                rep_cnt_nxt = '0;
            end else begin
                rep_cnt_nxt = sat_inc(rep_cnt);
            end
        end else if (rel_evt || state == ST_IDLE || state == ST_PRESS_WAIT) begin
            rep_cnt_nxt   = '0;
            rep_phase_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_phase <= rep_phase_nxt;
        end
    end

    assign press_fire = press_evt | rep_evt;
`else
    assign press_fire = press_evt;
`endif

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pressed       <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE_WAIT);
            press_pulse   <= press_fire;
            release_pulse <= rel_evt;
        end
    end

endmodule

// File: tb/tb_button_press_pulser.sv
// Self-checking bench for button_press_pulser: directed scenarios with literal
// expectations plus randomized bouncing, all checked against a run-length model.
module tb_button_press_pulser;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int np    = 0;
    int nr    = 0;
    int last_press_cyc   = -1;
    int last_release_cyc = -1;

    // Reference model state: synchroniser image, debounced level, current
    // run length of samples disagreeing with it, and edges spent held.
    bit m_s1, m_s2, deb;
    int run, hc;
    bit exp_press, exp_rel, exp_pressed;
    bit smp, ep, er;

    button_press_pulser #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (8)
    ) dut (
        .CLK_IN        (clk),
        .RST           (rst),
        .button        (button),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        total = total + 1;
        if (got !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // A level change is accepted once D+1 consecutive synchronised samples
    // disagree with the current debounced level.
    always @(posedge clk) begin
        ep = 1'b0;
        er = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; deb = 1'b0; run = 0; hc = 0;
        end else begin
            smp = m_s2;
`ifdef BUTTON_PRESS_PULSER_AUTOREPEAT_EN
            if (deb && smp && run == 0) begin
                hc = hc + 1;
                if (hc == RD || (hc > RD && (hc - RD) % RP == 0)) ep = 1'b1;
            end
`endif
            if (smp != deb) begin
                run = run + 1;
                if (run == D + 1) begin
                    deb = smp;
                    run = 0;
                    if (smp) ep = 1'b1;
                    else begin
                        er = 1'b1;
                        hc = 0;
                    end
                end
            end else begin
                run = 0;
            end
            m_s2 = m_s1;
            m_s1 = button;
        end
        exp_press   = ep;
        exp_rel     = er;
        exp_pressed = deb;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("press_pulse", int'(press_pulse), int'(exp_press));
            check("release_pulse", int'(release_pulse), int'(exp_rel));
            check("pressed", int'(pressed), int'(exp_pressed));
            check("pulse_exclusive", int'(press_pulse & release_pulse), 0);
            if (press_pulse === 1'b1) begin
                np = np + 1;
                last_press_cyc = cyc;
            end
            if (release_pulse === 1'b1) begin
                nr = nr + 1;
                last_release_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, np0, nr0;
        bit pat [12];
        rst = 1'b1;
        button = 1'b1;
        tick(5);
        check("reset_no_press", np, 0);
        check("reset_pressed_low", int'(pressed), 0);

        rst = 1'b0;
        t0 = cyc;
        tick(12);
        check("post_reset_press_cnt", np, 1);
        check("post_reset_latency", last_press_cyc - t0, 7);
        check("post_reset_pressed", int'(pressed), 1);
        button = 1'b0;
        t0 = cyc;
        tick(12);
        check("post_reset_release_cnt", nr, 1);
        check("post_reset_rel_latency", last_release_cyc - t0, 7);

        np0 = np; nr0 = nr;
        button = 1'b1;
        t0 = cyc;
        tick(20);
        check("clean_press_cnt", np - np0, 1);
        check("clean_press_latency", last_press_cyc - t0, 7);
        button = 1'b0;
        t0 = cyc;
        tick(12);
        check("clean_release_cnt", nr - nr0, 1);
        check("clean_release_latency", last_release_cyc - t0, 7);

        pat = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        np0 = np; nr0 = nr;
        for (int i = 0; i < 12; i++) begin
            button = pat[i];
            tick(1);
        end
        tick(6);
        check("bounce_no_early_press", np - np0, 0);
        button = 1'b1;
        t0 = cyc;
        tick(20);
        check("bounce_press_cnt", np - np0, 1);
        check("bounce_press_latency", last_press_cyc - t0, 7);
        button = 1'b0;
        tick(12);

        np0 = np; nr0 = nr;
        button = 1'b1;
        tick(12);
        button = 1'b0;
        tick(2);
        button = 1'b1;
        tick(3);
        check("rel_glitch_pressed", int'(pressed), 1);
        check("rel_glitch_no_release", nr - nr0, 0);
        tick(5);
        button = 1'b0;
        tick(12);
        check("rel_glitch_press_cnt", np - np0, 1);
        check("rel_glitch_release_cnt", nr - nr0, 1);

        np0 = np;
        button = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        t0 = cyc;
        check("mid_pw_reset_no_press", np - np0, 0);
        tick(12);
        check("mid_pw_repress_cnt", np - np0, 1);
        check("mid_pw_repress_latency", last_press_cyc - t0, 7);
        button = 1'b0;
        tick(12);

        np0 = np;
        button = 1'b1;
        tick(60);
        button = 1'b0;
        tick(15);
`ifdef BUTTON_PRESS_PULSER_AUTOREPEAT_EN
        check("long_hold_press_cnt", np - np0, 6);
`else
        check("long_hold_press_cnt", np - np0, 1);
`endif

        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end
            button = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 9));
        end
        button = 1'b0;
        tick(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
